// File: rtl/sva_and_monitor.sv
// Hardware monitor for $rose(start) |=> (##D_A a) and (b ##D_STOP stop).
// Optional SVA twin and fail-count cross-check: SVA_AND_MON_ASSERT_EN.
module sva_and_monitor #(
  parameter int N_CH   = 1,
  parameter int D_A    = 1,
  parameter int D_STOP = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [N_CH-1:0]   start,
  input  logic [N_CH-1:0]   a,
  input  logic [N_CH-1:0]   b,
  input  logic [N_CH-1:0]   stop,
  output logic [N_CH-1:0]   pass,
  output logic [N_CH-1:0]   fail,
  output logic [3*N_CH-1:0] fail_cause,
  output logic [N_CH-1:0]   busy,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              sticky_fail
);

  localparam int DMAX = (D_A > D_STOP) ? D_A : D_STOP;
  localparam int L    = 1 + DMAX;
  localparam int SW   = $clog2(N_CH * L + 1);
  localparam int EW   = ((CNT_W > SW) ? CNT_W : SW) + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [N_CH-1:0]   start_q;
  logic [L-1:0]      vld   [N_CH];
  logic [L-1:0]      vld_n [N_CH];
  logic [L-1:0]      surv;
  logic [N_CH-1:0]   trig;
  logic [N_CH-1:0]   pass_n;
  logic [N_CH-1:0]   fail_n;
  logic [N_CH-1:0]   busy_n;
  logic [3*N_CH-1:0] cause_n;
  logic [SW-1:0]     pass_sum;
  logic [SW-1:0]     fail_sum;
  logic              mb;
  logic              ma;
  logic              ms;

  assign trig = start & ~start_q & {N_CH{en}};

  // Stage j holds the attempt triggered j+1 edges ago.
  always_comb begin
    pass_n   = '0;
    fail_n   = '0;
    busy_n   = '0;
    cause_n  = '0;
    pass_sum = '0;
    fail_sum = '0;
    surv     = '0;
    mb       = 1'b0;
    ma       = 1'b0;
    ms       = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      surv = '0;
      for (int j = 0; j < L; j++) begin
        mb = (j == 0) && !b[c];
        ma = (j == D_A) && !a[c];
        ms = (j == D_STOP) && !stop[c];
        if (vld[c][j]) begin
          if (mb || ma || ms) begin
            fail_n[c] = 1'b1;
            cause_n[3*c +: 3] = cause_n[3*c +: 3] | {ms, ma, mb};
            fail_sum = fail_sum + SW'(1);
          end else if (j == L - 1) begin
            pass_n[c] = 1'b1;
            pass_sum = pass_sum + SW'(1);
          end else begin
            surv[j] = 1'b1;
          end
        end
      end
      vld_n[c]  = (surv << 1) | L'(trig[c]);
      busy_n[c] = (|vld_n[c]) | pass_n[c] | fail_n[c];
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] x,
    input logic [SW-1:0]    d
  );
    logic [EW-1:0] s;
    s = EW'(x) + EW'(d);
    return (s > EW'(CMAX)) ? CMAX : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= '0;
      for (int c = 0; c < N_CH; c++) vld[c] <= '0;
      pass        <= '0;
      fail        <= '0;
      fail_cause  <= '0;
      busy        <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      sticky_fail <= 1'b0;
    end else begin
      start_q    <= start;
      for (int c = 0; c < N_CH; c++) vld[c] <= vld_n[c];
      pass       <= pass_n;
      fail       <= fail_n;
      fail_cause <= cause_n;
      busy       <= busy_n;
      if (clr) begin
        pass_cnt    <= '0;
        fail_cnt    <= '0;
        sticky_fail <= 1'b0;
      end else begin
        pass_cnt    <= sat_add(pass_cnt, pass_sum);
        fail_cnt    <= sat_add(fail_cnt, fail_sum);
        sticky_fail <= sticky_fail | (|fail_n);
      end
    end
  end

`ifdef SVA_AND_MON_ASSERT_EN
  // Matches fail_cnt only while no clr or saturation has occurred.
  int unsigned sva_fails = 0;

  for (genvar g = 0; g < N_CH; g++) begin : g_sva
    p_and: assert property (
      @(posedge clk) disable iff (!rst_n)
      (en && $rose(start[g])) |=>
        ((##D_A a[g]) and (b[g] ##D_STOP stop[g])))
    else begin
      sva_fails++;
      $error("sva_and_monitor: ch %0d failed", g);
    end
  end

  final begin
    if (sva_fails != int'(fail_cnt))
      $error("sva_and_monitor: sva=%0d fail_cnt=%0d",
             sva_fails, fail_cnt);
  end
`else
  // synthesizable build: monitor logic only
`endif

endmodule

// File: tb/tb_sva_and_monitor.sv
// Random + directed bench for sva_and_monitor.
// Attempt-list reference model feeds a scoreboard queue.
module tb_sva_and_monitor;

  localparam int N_CH   = 2;
  localparam int D_A    = 1;
  localparam int D_STOP = 2;
  localparam int CNT_W  = 4;
  localparam int LAST   = 1 + ((D_A > D_STOP) ? D_A : D_STOP);
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic [N_CH-1:0]   start = '0;
  logic [N_CH-1:0]   a = '0;
  logic [N_CH-1:0]   b = '0;
  logic [N_CH-1:0]   stop = '0;
  logic [N_CH-1:0]   pass;
  logic [N_CH-1:0]   fail;
  logic [3*N_CH-1:0] fail_cause;
  logic [N_CH-1:0]   busy;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic              sticky_fail;

  always #5 clk = ~clk;

  sva_and_monitor #(
    .N_CH   (N_CH),
    .D_A    (D_A),
    .D_STOP (D_STOP),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .start       (start),
    .a           (a),
    .b           (b),
    .stop        (stop),
    .pass        (pass),
    .fail        (fail),
    .fail_cause  (fail_cause),
    .busy        (busy),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .sticky_fail (sticky_fail)
  );

  typedef struct {
    logic [N_CH-1:0]   pass;
    logic [N_CH-1:0]   fail;
    logic [N_CH-1:0]   busy;
    logic [3*N_CH-1:0] cause;
    logic [CNT_W-1:0]  pc;
    logic [CNT_W-1:0]  fc;
    logic              sticky;
  } exp_t;

  typedef struct {
    int ch;
    int t;
  } att_t;

  exp_t exq[$];
  att_t atts[$];
  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int m_pc = 0;
  int m_fc = 0;
  logic m_sticky = 1'b0;
  logic [N_CH-1:0] m_prev = '0;

  // Attempts are a list of trigger times; checks fire by elapsed edges.
  task automatic model();
    exp_t e;
    att_t keep[$];
    int k, ch, np, nf;
    logic fb, fa, fs;
    e = '{default: '0};
    np = 0;
    nf = 0;
    edge_n++;
    if (!rst_n) begin
      atts.delete();
      m_pc = 0;
      m_fc = 0;
      m_sticky = 1'b0;
      m_prev = '0;
      exq.push_back(e);
      return;
    end
    foreach (atts[i]) begin
      k  = edge_n - atts[i].t;
      ch = atts[i].ch;
      fb = (k == 1) && !b[ch];
      fa = (k == 1 + D_A) && !a[ch];
      fs = (k == 1 + D_STOP) && !stop[ch];
      if (fb || fa || fs) begin
        e.fail[ch] = 1'b1;
        e.cause[3*ch +: 3] = e.cause[3*ch +: 3] | {fs, fa, fb};
        nf++;
      end else if (k == LAST) begin
        e.pass[ch] = 1'b1;
        np++;
      end else begin
        keep.push_back(atts[i]);
      end
    end
    for (int c = 0; c < N_CH; c++)
      if (en && start[c] && !m_prev[c])
        keep.push_back('{c, edge_n});
    m_prev = start;
    foreach (keep[i]) e.busy[keep[i].ch] = 1'b1;
    e.busy = e.busy | e.pass | e.fail;
    if (clr) begin
      m_pc = 0;
      m_fc = 0;
      m_sticky = 1'b0;
    end else begin
      m_pc = (m_pc + np > CMAX) ? CMAX : m_pc + np;
      m_fc = (m_fc + nf > CMAX) ? CMAX : m_fc + nf;
      m_sticky = m_sticky | (nf != 0);
    end
    e.pc = CNT_W'(m_pc);
    e.fc = CNT_W'(m_fc);
    e.sticky = m_sticky;
    atts = keep;
    exq.push_back(e);
  endtask

  task automatic step(
    input logic [N_CH-1:0] s, av, bv, sv,
    input logic e_, c_, r_
  );
    @(negedge clk);
    start = s;
    a = av;
    b = bv;
    stop = sv;
    en = e_;
    clr = c_;
    rst_n = r_;
    @(posedge clk);
    model();
  endtask

  // Channel 0 only, channel 1 idle with checks satisfied.
  task automatic go(
    input logic s, av, bv, sv, e_, c_
  );
    step({1'b0, s}, {1'b1, av}, {1'b1, bv},
         {1'b1, sv}, e_, c_, 1'b1);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h",
               nm, edge_n, act, req);
    end
  endtask

  exp_t me;

  always @(posedge clk) begin
    #1;
    if (exq.size() != 0) begin
      me = exq.pop_front();
      chk("pass", 32'(pass), 32'(me.pass));
      chk("fail", 32'(fail), 32'(me.fail));
      chk("cause", 32'(fail_cause), 32'(me.cause));
      chk("busy", 32'(busy), 32'(me.busy));
      chk("pass_cnt", 32'(pass_cnt), 32'(me.pc));
      chk("fail_cnt", 32'(fail_cnt), 32'(me.fc));
      chk("sticky", 32'(sticky_fail), 32'(me.sticky));
    end
  end

  initial begin
    step('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    step('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    // basic pass
    go(0, 1, 1, 1, 1, 0);
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    // b missing
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 0, 1, 1, 0);
    go(0, 0, 1, 0, 1, 0);
    go(0, 0, 1, 0, 1, 0);
    // overlap, second fails on stop
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 0, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    // same-edge pass and fail
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 0, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    // en low at second rising start
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(1, 1, 1, 1, 0, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    // reset mid-attempt
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    step('0, '1, '1, '1, 1'b1, 1'b0, 1'b0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    // clr together with a pass
    go(1, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 0);
    go(0, 1, 1, 1, 1, 1);
    go(0, 1, 1, 1, 1, 0);
    // saturation: many passes on both channels
    for (int i = 0; i < 20; i++) begin
      step('1, '1, '1, '1, 1'b1, 1'b0, 1'b1);
      step('0, '1, '1, '1, 1'b1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 12; i++) begin
      step('1, '1, '0, '1, 1'b1, 1'b0, 1'b1);
      step('0, '1, '0, '1, 1'b1, 1'b0, 1'b1);
    end
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [N_CH-1:0] rs, ra, rb, rp;
      for (int c = 0; c < N_CH; c++) begin
        rs[c] = ($urandom_range(0, 99) < 35);
        ra[c] = ($urandom_range(0, 99) < 85);
        rb[c] = ($urandom_range(0, 99) < 85);
        rp[c] = ($urandom_range(0, 99) < 85);
      end
      step(rs, ra, rb, rp,
           $urandom_range(0, 99) < 90,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) != 0);
    end
    step('0, '1, '1, '1, 1'b1, 1'b0, 1'b1);
    step('0, '1, '1, '1, 1'b1, 1'b0, 1'b1);
    step('0, '1, '1, '1, 1'b1, 1'b0, 1'b1);
    step('0, '1, '1, '1, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", 32'(exq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
